// File: rtl/period_meter_pkg.sv
// Shared types and constants for the blink period meter.
// Filter depth only matters when PERIOD_METER_GLITCH_FILTER_EN is defined.
package period_meter_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    typedef enum logic [0:0] {
        IDLE    = ST_IDLE,
        MEASURE = ST_MEASURE
    } state_e;

    // Consecutive equal synchronized samples required before a new level is accepted
    localparam int unsigned FILT_DEPTH = 4;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: counts 0..CLK_PER_MS-1 and pulses tick on the last count.
// clr realigns the millisecond boundary; a tick coinciding with clr is still reported.
module ms_tick_gen
    import period_meter_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    CW   = cnt_width(CLK_PER_MS);
    localparam logic [CW-1:0]  LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures the interval between consecutive blink_in transitions in whole milliseconds.
// Define PERIOD_METER_GLITCH_FILTER_EN to require FILT_DEPTH equal samples before accepting a level.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned W          = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blink_in,
    output logic [W-1:0] period_ms,
    output logic         valid,
    output logic         overflow
);

    logic [1:0]   sync_q;
    logic         lvl;
    logic         prev_q;
    logic         edge_q;
    logic         tick;
    logic         sat;

    state_e       state_q, state_d;
    logic [W-1:0] ms_cnt_q, ms_cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], blink_in};
        end
    end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
    logic [FILT_DEPTH-2:0] hist_q;
    logic                  filt_q;

    // Current synchronized sample plus FILT_DEPTH-1 history samples must agree
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[FILT_DEPTH-3:0], sync_q[1]};
            if (hist_q == {(FILT_DEPTH-1){sync_q[1]}}) begin
                filt_q <= sync_q[1];
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            prev_q <= lvl;
            edge_q <= lvl ^ prev_q;
        end
    end

    ms_tick_gen #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (edge_q),
        .tick  (tick)
    );

    assign sat = tick && (ms_cnt_q == '1);

    always_comb begin
        state_d  = state_q;
        ms_cnt_d = ms_cnt_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (edge_q) begin
                    state_d  = MEASURE;
                    ms_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (sat) begin
                    // Interval no longer representable; an edge landing here becomes the new reference
                    ovf_d    = 1'b1;
                    ms_cnt_d = '0;
                    if (!edge_q) begin
                        state_d = IDLE;
                    end
                end else if (edge_q) begin
                    period_d = ms_cnt_q + W'(tick);
                    valid_d  = 1'b1;
                    ovf_d    = 1'b0;
                    ms_cnt_d = '0;
                end else if (tick) begin
                    ms_cnt_d = ms_cnt_q + W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign period_ms = period_q;
    assign valid     = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CLK_PER_MS, default 100000, clock cycles per millisecond; legal range 2..2^17-1.
REQ-002 Parameter W, default 16, width of the millisecond count and result.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 blink_in  input  1  asynchronous level to be measured, e.g. an LED drive line toggling every N ms.
REQ-006 period_ms  output  W  last measured interval between consecutive blink_in transitions, in whole ms.
REQ-007 valid  output  1  one-cycle pulse; period_ms updated in the same cycle.
REQ-008 overflow  output  1  sticky flag; interval exceeded 2^W-1 ms since the last accepted edge.

Function
REQ-009 blink_in SHALL pass through a 2-flop synchronizer; a transition is any change between the synchronized level and its one-cycle-delayed copy, rising or falling.
REQ-010 A ms tick counter SHALL count 0..CLK_PER_MS-1 and emit a one-cycle tick when at CLK_PER_MS-1, then wrap to 0.
REQ-011 The tick counter SHALL reset to 0 in the cycle a transition is detected, aligning ms boundaries to the edge.
REQ-012 FSM states: IDLE (no reference edge yet) and MEASURE.
REQ-013 IDLE: on transition -> MEASURE, clear ms_cnt, no valid pulse.
REQ-014 MEASURE: on tick, ms_cnt increments by 1.
REQ-015 MEASURE: on transition, period_ms <= ms_cnt (ms_cnt+1 if a tick coincides), valid pulses 1 cycle, overflow clears, ms_cnt <= 0, stay in MEASURE.
REQ-016 MEASURE: when a tick would take ms_cnt past 2^W-1, overflow SHALL set, period_ms SHALL hold, no valid pulse, and the FSM SHALL go to IDLE.
REQ-017 Latency: valid SHALL be high exactly 3 clk cycles after the first rising edge that samples the new blink_in level (without the glitch filter).
REQ-018 Transitions spaced under 1 ms SHALL report period_ms = 0.
REQ-019 ms_cnt arithmetic is W-bit unsigned; no wrap-around is ever reported as a valid result.

Reset
REQ-020 Reset SHALL force period_ms = 0, valid = 0, and overflow = 0.
REQ-021 Reset SHALL force the FSM to IDLE and clear the tick counter, ms_cnt and synchronizer flops to 0.
REQ-022 Reset mid-measurement SHALL discard the partial interval; the first edge after reset SHALL produce no valid.

Configuration
REQ-023 Macro PERIOD_METER_GLITCH_FILTER_EN: when defined, the synchronized level SHALL be accepted only after 4 consecutive equal samples.
REQ-024 With the filter, pulses shorter than 4 clk are ignored and valid latency becomes 7 cycles.
REQ-025 When the macro is undefined, no filter logic SHALL exist and REQ-017 latency applies.

Structure
REQ-026 Package period_meter_pkg SHALL hold the FSM state enum (IDLE, MEASURE) and the filter depth constant (4).
REQ-027 The ms tick generator SHALL be a sub-module ms_tick_gen (parameter CLK_PER_MS; ports clk, reset, clr, tick).

Verification (bench uses CLK_PER_MS=10)
REQ-028 Assert reset with blink_in toggling -> period_ms=0, valid=0, overflow=0, and no valid on the first post-reset edge.
REQ-029 blink_in toggles every 500 clk -> first edge no valid; each later edge gives valid with period_ms=50.
REQ-030 Intervals of 30 clk then 70 clk -> valid with period_ms=3, then valid with period_ms=7.
REQ-031 W=4, no edge for 200 clk -> overflow=1 and no valid; then two edges 50 clk apart -> valid, period_ms=5, overflow=0.
REQ-032 Reset asserted 250 clk into a 500-clk interval -> outputs zero; next edge no valid; following edge 500 clk later -> period_ms=50.
REQ-033 2-clk glitch on blink_in -> with macro: no valid; without macro: valid with period_ms=0 on the glitch's second edge.
